z80_irq_ctrl: RTL and testbench

Eight-input vectored interrupt controller that sits directly upstream of the tv80s CPU. It drives the CPU `int_n` input and supplies the vector byte on the CPU data-in mux during the interrupt-acknowledge cycle (`m1_n` = 0 and `iorq_n` = 0), replacing the fixed 8'hE7 IRQ device. The CPU configures and services it through four I/O ports. It provides edge-latched requests, a mask, fully-nested priority with in-service tracking, and software end-of-interrupt (EOI).

---
 rtl/z80_irq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_z80_irq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_irq_ctrl.sv
// Eight-input vectored interrupt controller for the tv80s: edge-latched requests,
// mask, fully-nested priority with in-service tracking, and software EOI.
module z80_irq_ctrl #(
  parameter logic [7:0] BASE_PORT = 8'h40
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_irq,
  input  logic [7:0] i_a,
  input  logic [7:0] i_di,
  input  logic       i_m1_n,
  input  logic       i_iorq_n,
  input  logic       i_rd_n,
  input  logic       i_wr_n,
  output logic [7:0] o_do,
  output logic       o_do_oe,
  output logic       o_int_n
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sync1_q, sync2_q, prev_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] imr_q, imr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] vec_q, vec_d;
  logic [2:0] ack_n_q, ack_n_d;
  logic       ack_valid_q, ack_valid_d;
  logic       wr_act_q, wr_act_d;
  logic       int_n_q, int_n_d;

  logic       inta, io_sel, io_rd, io_wr, wr_fire;
  logic [7:0] offs;
  logic [1:0] reg_sel;
  logic [7:0] rise;
  logic [7:0] irr_clr;
  logic [7:0] eoi_clr;
  logic       win_valid;
  logic [2:0] win_n;
  logic       blocked;

  function automatic logic [7:0] vector_byte(input logic [3:0] base, input logic im2,
                                             input logic [2:0] n);
    if (im2) return {base, n, 1'b0};
    return 8'hC7 | {2'b00, n, 3'b000};
  endfunction

  assign inta    = !i_m1_n && !i_iorq_n;
  assign offs    = i_a - BASE_PORT;
  assign reg_sel = offs[1:0];
  assign io_sel  = !i_iorq_n && i_m1_n && (offs[7:2] == 6'd0);
  assign io_rd   = io_sel && !i_rd_n;
  assign io_wr   = io_sel && !i_wr_n;
  // A held write strobe acts only on its first sampled edge.
  assign wr_fire = io_wr && !wr_act_q;
  assign rise    = sync2_q & ~prev_q;
  // Isolates the lowest set in-service bit (zero when nothing is in service).
  assign eoi_clr = isr_q & (~isr_q + 8'd1);

  always_comb begin
    win_valid = 1'b0;
    win_n     = 3'd7;
    blocked   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      blocked = blocked | isr_q[i];
      if (!win_valid && !blocked && irr_q[i] && !imr_q[i]) begin
        win_valid = 1'b1;
        win_n     = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_n_d     = ack_n_q;
    ack_valid_d = ack_valid_q;
    irr_clr     = 8'h00;
    imr_d       = imr_q;
    isr_d       = isr_q;
    vec_d       = vec_q;

    case (state_q)
      ST_IDLE: begin
        if (inta) begin
          state_d     = ST_ACK;
          ack_n_d     = win_n;
          ack_valid_d = win_valid;
        end
      end
      ST_ACK: begin
        if (!inta) begin
          state_d     = ST_IDLE;
          ack_valid_d = 1'b0;
          if (ack_valid_q) begin
            irr_clr[ack_n_q] = 1'b1;
            isr_d[ack_n_q]   = 1'b1;
          end
        end
      end
    endcase

    if (wr_fire) begin
      case (reg_sel)
        2'd0: irr_clr = irr_clr | i_di;
        2'd1: imr_d   = i_di;
        2'd2: isr_d   = isr_q & ~eoi_clr;
        2'd3: vec_d   = i_di;
      endcase
    end

    // A new edge on the same bit outranks any clear in the same cycle.
    irr_d    = (irr_q & ~irr_clr) | rise;
    int_n_d  = !(win_valid || (state_q == ST_ACK));
    wr_act_d = io_wr;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 8'h00;
      sync2_q     <= 8'h00;
      prev_q      <= 8'h00;
      irr_q       <= 8'h00;
      imr_q       <= 8'hFF;
      isr_q       <= 8'h00;
      vec_q       <= 8'h00;
      ack_n_q     <= 3'd7;
      ack_valid_q <= 1'b0;
      wr_act_q    <= 1'b0;
      int_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      sync1_q     <= i_irq;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      irr_q       <= irr_d;
      imr_q       <= imr_d;
      isr_q       <= isr_d;
      vec_q       <= vec_d;
      ack_n_q     <= ack_n_d;
      ack_valid_q <= ack_valid_d;
      wr_act_q    <= wr_act_d;
      int_n_q     <= int_n_d;
    end
  end

  // The data-in select is released the moment reset asserts, even mid-acknowledge.
  always_comb begin
    o_do    = 8'h00;
    o_do_oe = 1'b0;
    if (i_reset_n) begin
      if (inta) begin
        o_do_oe = 1'b1;
        o_do    = vector_byte(vec_q[7:4], vec_q[0], (state_q == ST_ACK) ? ack_n_q : win_n);
      end else if (io_rd) begin
        o_do_oe = 1'b1;
        case (reg_sel)
          2'd0: o_do = irr_q;
          2'd1: o_do = imr_q;
          2'd2: o_do = isr_q;
          2'd3: o_do = vec_q;
        endcase
      end
    end
  end

  assign o_int_n = int_n_q;

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Self-checking bench for z80_irq_ctrl: directed scenarios plus a randomized
// sequence scored against a register-level model of the controller.
module tb_z80_irq_ctrl;
  localparam logic [7:0] BASE = 8'h40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq = 8'h00;
  logic [7:0] a = 8'h00, di = 8'h00;
  logic       m1_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0] dout;
  logic       oe, int_n;

  int total = 0;
  int passed = 0;

  logic [7:0] m_irr, m_imr, m_isr, m_vec;

  z80_irq_ctrl #(.BASE_PORT(BASE)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_irq(irq), .i_a(a), .i_di(di),
    .i_m1_n(m1_n), .i_iorq_n(iorq_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
    .o_do(dout), .o_do_oe(oe), .o_int_n(int_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    a = 8'h00; di = 8'h00; m1_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  function automatic int m_winner();
    for (int n = 0; n < 8; n++)
      if (m_irr[n] && !m_imr[n] && (int'(m_isr) % (1 << (n + 1))) == 0) return n;
    return -1;
  endfunction

  function automatic logic [7:0] m_vector(input int n);
    int k;
    k = (n < 0) ? 7 : n;
    if (m_vec[0]) return (m_vec & 8'hF0) + 8'(k * 2);
    return 8'hC7 + 8'(k * 8);
  endfunction

  function automatic void m_reset();
    m_irr = 8'h00; m_imr = 8'hFF; m_isr = 8'h00; m_vec = 8'h00;
  endfunction

  function automatic void m_eoi();
    for (int i = 0; i < 8; i++)
      if (m_isr[i]) begin
        m_isr[i] = 1'b0;
        return;
      end
  endfunction

  task automatic io_write(input logic [1:0] off, input logic [7:0] d);
    a = BASE + 8'(off); di = d; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    bus_idle();
    tick();
    case (off)
      2'd0: m_irr = m_irr & ~d;
      2'd1: m_imr = d;
      2'd2: m_eoi();
      2'd3: m_vec = d;
    endcase
    $display("io write port +%0d data %h", off, d);
  endtask

  task automatic io_read(input logic [1:0] off, output logic [7:0] d);
    a = BASE + 8'(off); m1_n = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    d = dout;
    bus_idle();
    #1;
  endtask

  task automatic pulse(input logic [7:0] mask);
    irq = mask;
    repeat (3) tick();
    irq = 8'h00;
    repeat (3) tick();
    m_irr = m_irr | mask;
    $display("irq pulse %h", mask);
  endtask

  task automatic inta(output logic [7:0] v_idle, output logic [7:0] v_ack, output logic oe_seen);
    int n;
    n = m_winner();
    m1_n = 1'b0; iorq_n = 1'b0;
    #1;
    v_idle = dout; oe_seen = oe;
    tick();
    v_ack = dout;
    bus_idle();
    tick();
    tick();
    if (n >= 0) begin
      m_irr[n] = 1'b0;
      m_isr[n] = 1'b1;
    end
    $display("inta vector idle %h ack %h", v_idle, v_ack);
  endtask

  task automatic do_reset();
    irq = 8'h00; bus_idle(); rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1; m_reset();
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] r;
    irq = 8'hFF; bus_idle(); rst_n = 1'b0;
    tick(); tick();
    total++; if (oe !== 1'b0 || dout !== 8'h00) $display("FAIL reset_out oe=%b do=%h want 0/00", oe, dout); else passed++;
    total++; if (int_n !== 1'b1) $display("FAIL reset_int_n got %b want 1", int_n); else passed++;
    rst_n = 1'b1; m_reset();
    #1;
    io_read(2'd0, r); total++; if (r !== 8'h00) $display("FAIL reset_irr got %h want 00", r); else passed++;
    io_read(2'd1, r); total++; if (r !== 8'hFF) $display("FAIL reset_imr got %h want FF", r); else passed++;
    io_read(2'd2, r); total++; if (r !== 8'h00) $display("FAIL reset_isr got %h want 00", r); else passed++;
    io_read(2'd3, r); total++; if (r !== 8'h00) $display("FAIL reset_vec got %h want 00", r); else passed++;
    repeat (5) tick();
    m_irr = 8'hFF;
    total++; if (int_n !== 1'b1) $display("FAIL masked_int_n got %b want 1", int_n); else passed++;
    io_read(2'd0, r); total++; if (r !== 8'hFF) $display("FAIL masked_irr got %h want FF", r); else passed++;
    irq = 8'h00;
    repeat (3) tick();
    io_write(2'd0, 8'hFF);
  endtask

  task automatic test_rst_mode();
    logic [7:0] r, vi, va;
    logic o;
    io_write(2'd1, 8'h00);
    irq = 8'h10;
    tick();
    tick();
    io_read(2'd0, r); total++; if (r !== 8'h00) $display("FAIL lat_irr_k1 got %h want 00", r); else passed++;
    tick();
    io_read(2'd0, r); total++; if (r !== 8'h10) $display("FAIL lat_irr_k2 got %h want 10", r); else passed++;
    total++; if (int_n !== 1'b1) $display("FAIL lat_int_k2 got %b want 1", int_n); else passed++;
    tick();
    total++; if (int_n !== 1'b0) $display("FAIL lat_int_k3 got %b want 0", int_n); else passed++;
    irq = 8'h00;
    repeat (3) tick();
    m_irr = m_irr | 8'h10;
    inta(vi, va, o);
    total++; if (vi !== 8'hE7 || va !== 8'hE7 || o !== 1'b1) $display("FAIL rst_vec got %h/%h oe=%b want E7", vi, va, o); else passed++;
    io_read(2'd2, r); total++; if (r !== 8'h10) $display("FAIL rst_isr got %h want 10", r); else passed++;
    io_read(2'd0, r); total++; if (r !== 8'h00) $display("FAIL rst_irr got %h want 00", r); else passed++;
    total++; if (int_n !== 1'b1) $display("FAIL rst_int_after got %b want 1", int_n); else passed++;
    io_write(2'd2, 8'h00);
    io_read(2'd2, r); total++; if (r !== 8'h00) $display("FAIL rst_eoi got %h want 00", r); else passed++;
  endtask

  task automatic test_im2_nesting();
    logic [7:0] r, vi, va;
    logic o;
    io_write(2'd3, 8'hA1);
    io_write(2'd1, 8'h00);
    pulse(8'h20);
    inta(vi, va, o);
    total++; if (va !== 8'hAA) $display("FAIL im2_vec5 got %h want AA", va); else passed++;
    pulse(8'h40);
    total++; if (int_n !== 1'b1) $display("FAIL im2_block6 got %b want 1", int_n); else passed++;
    pulse(8'h04);
    total++; if (int_n !== 1'b0) $display("FAIL im2_nest2 got %b want 0", int_n); else passed++;
    inta(vi, va, o);
    total++; if (va !== 8'hA4) $display("FAIL im2_vec2 got %h want A4", va); else passed++;
    io_read(2'd2, r); total++; if (r !== 8'h24) $display("FAIL im2_isr24 got %h want 24", r); else passed++;
    io_write(2'd2, 8'h00);
    tick();
    io_read(2'd2, r); total++; if (r !== 8'h20) $display("FAIL im2_eoi1 got %h want 20", r); else passed++;
    total++; if (int_n !== 1'b1) $display("FAIL im2_still_block got %b want 1", int_n); else passed++;
    io_write(2'd2, 8'h00);
    tick();
    total++; if (int_n !== 1'b0) $display("FAIL im2_eoi_release got %b want 0", int_n); else passed++;
    io_read(2'd2, r); total++; if (r !== 8'h00) $display("FAIL im2_eoi2 got %h want 00", r); else passed++;
    inta(vi, va, o);
    total++; if (va !== 8'hAC) $display("FAIL im2_vec6 got %h want AC", va); else passed++;
    io_write(2'd2, 8'h00);
  endtask

  task automatic test_simultaneous();
    logic [7:0] vi, va;
    logic o;
    io_write(2'd3, 8'h00);
    io_write(2'd1, 8'h00);
    pulse(8'h0A);
    inta(vi, va, o);
    total++; if (va !== 8'hCF) $display("FAIL simul_first got %h want CF", va); else passed++;
    io_write(2'd2, 8'h00);
    tick();
    inta(vi, va, o);
    total++; if (va !== 8'hDF) $display("FAIL simul_second got %h want DF", va); else passed++;
    io_write(2'd2, 8'h00);
  endtask

  task automatic test_mask_clear();
    logic [7:0] r;
    io_write(2'd1, 8'h08);
    pulse(8'h08);
    io_read(2'd0, r); total++; if (r !== 8'h08) $display("FAIL mask_irr got %h want 08", r); else passed++;
    total++; if (int_n !== 1'b1) $display("FAIL mask_int_n got %b want 1", int_n); else passed++;
    io_write(2'd0, 8'h08);
    io_read(2'd0, r); total++; if (r !== 8'h00) $display("FAIL clr_irr got %h want 00", r); else passed++;
    irq = 8'h08;
    tick();
    tick();
    a = BASE; di = 8'h08; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    bus_idle();
    irq = 8'h00;
    repeat (3) tick();
    m_irr = 8'h08;
    io_read(2'd0, r); total++; if (r !== 8'h08) $display("FAIL set_wins got %h want 08", r); else passed++;
    io_write(2'd0, 8'hFF);
    io_write(2'd1, 8'h00);
  endtask

  task automatic test_multi_wr_reset();
    logic [7:0] r, vi, va;
    logic o;
    pulse(8'h04);
    inta(vi, va, o);
    total++; if (va !== 8'hD7) $display("FAIL mw_vec2 got %h want D7", va); else passed++;
    pulse(8'h02);
    inta(vi, va, o);
    total++; if (va !== 8'hCF) $display("FAIL mw_vec1 got %h want CF", va); else passed++;
    io_read(2'd2, r); total++; if (r !== 8'h06) $display("FAIL mw_isr06 got %h want 06", r); else passed++;
    a = BASE + 8'd2; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (3) tick();
    bus_idle();
    tick();
    m_eoi();
    io_read(2'd2, r); total++; if (r !== 8'h04) $display("FAIL mw_once got %h want 04", r); else passed++;
    pulse(8'h01);
    total++; if (int_n !== 1'b0) $display("FAIL abort_pre_int got %b want 0", int_n); else passed++;
    m1_n = 1'b0; iorq_n = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    total++; if (oe !== 1'b0) $display("FAIL abort_oe got %b want 0", oe); else passed++;
    total++; if (int_n !== 1'b1) $display("FAIL abort_int_n got %b want 1", int_n); else passed++;
    tick();
    bus_idle();
    tick();
    rst_n = 1'b1; m_reset();
    #1;
    io_read(2'd2, r); total++; if (r !== 8'h00) $display("FAIL abort_isr got %h want 00", r); else passed++;
    io_read(2'd0, r); total++; if (r !== 8'h00) $display("FAIL abort_irr got %h want 00", r); else passed++;
    io_read(2'd1, r); total++; if (r !== 8'hFF) $display("FAIL abort_imr got %h want FF", r); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] r, vi, va, exp;
    logic o;
    int op;
    do_reset();
    io_write(2'd1, 8'h00);
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: pulse(8'($urandom) & 8'($urandom));
        1: io_write(2'd1, 8'($urandom) & 8'($urandom) & 8'($urandom));
        2, 3: begin
          exp = m_vector(m_winner());
          inta(vi, va, o);
          total++; if (vi !== exp || va !== exp) $display("FAIL rnd_vec it=%0d got %h/%h want %h", it, vi, va, exp); else passed++;
        end
        4: io_write(2'd2, 8'($urandom));
        5: io_write(2'd3, 8'($urandom));
        default: io_write(2'd0, 8'($urandom));
      endcase
      tick();
      io_read(2'd0, r); total++; if (r !== m_irr) $display("FAIL rnd_irr it=%0d got %h want %h", it, r, m_irr); else passed++;
      io_read(2'd2, r); total++; if (r !== m_isr) $display("FAIL rnd_isr it=%0d got %h want %h", it, r, m_isr); else passed++;
      total++; if (int_n !== (m_winner() < 0)) $display("FAIL rnd_int_n it=%0d got %b want %b", it, int_n, (m_winner() < 0)); else passed++;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_rst_mode();
    test_im2_nesting();
    test_simultaneous();
    test_mask_clear();
    test_multi_wr_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
